switch_debounce: RTL and testbench
==================================

// Module: switch_debounce
// PURPOSE
//  Conditions the four raw board DIP-switch inputs before the LED controller and seven-segment decoder see them.
//  Synchronises the asynchronous switch vector into the HSOSC clock domain and filters contact bounce.
//  Publishes a debounced vector only after it has held constant for a programmable time.
//  Sits between the package pins and the top level's s[3:0] consumers.
// PARAMETERS
//  WIDTH          4       number of switch bits filtered as one vector
//  SYNC_STAGES    2       flip-flop stages per bit in the input synchroniser (>=2)
//  STABLE_CYCLES  480000  clocks the synchronised vector must hold before acceptance (10 ms @ 48 MHz; >=2)
// PORTS
//  clk      in   1      HSOSC-derived system clock; all flops on rising edge
//  reset    in   1      asynchronous, active-low reset
//  s_raw    in   WIDTH  raw switch pins, asynchronous to clk
//  s_db     out  WIDTH  debounced switch vector, drives led/seven-seg logic
//  settling out  1      high while a candidate change is being timed
// BEHAVIOUR
//  Reset (reset==0, async assert, sync release through clk):
//   - all synchroniser flops = 0, s_db = 0, settling = 0, state = STABLE, counter = 0.
//  Synchroniser: SYNC_STAGES-deep shift per bit; sync = last stage; no logic between stages.
//  FSM (state, cand[WIDTH-1:0], cnt[$clog2(STABLE_CYCLES)-1:0]):
//   STABLE:
//    - sync==s_db -> stay.
//    - sync!=s_db -> SETTLE, cand<=sync, cnt<=0.
//   SETTLE:
//    - sync==s_db (bounced back) -> STABLE, cnt<=0, s_db unchanged.
//    - else if sync!=cand -> cand<=sync, cnt<=0, stay (timer restarts on any bit change).
//    - else if cnt==STABLE_CYCLES-1 -> s_db<=cand, STABLE, cnt<=0.
//    - else -> cnt<=cnt+1.
//  settling = (state==SETTLE), registered with the state.
//  Latency: edge 0 is the first edge sampling a new steady s_raw. s_db shows the new value after edge SYNC_STAGES+STABLE_CYCLES.
//  Bounce: any change inside the window restarts timing, including a partial change of some bits.
//  Vector semantics: s_db never shows a mix of old and new bit values; all bits update on the same edge.
//  Counter never wraps; it saturates at STABLE_CYCLES-1 by construction of the transitions above.
//  Reset mid-SETTLE: candidate is discarded, s_db returns to 0, and filtering restarts from reset state.
//  Illegal state encoding -> STABLE on the next edge (default branch).
// CONFIGURATION
//  Macro DEBOUNCE_CHANGE_PULSE_EN:
//   - defined: extra outputs `changed` (1 bit) and `changed_mask` (WIDTH).
//     On the edge s_db updates, changed=1 for exactly one cycle and changed_mask = old s_db ^ new s_db.
//     Both outputs are 0 otherwise and 0 in reset.
//   - undefined: neither port exists and no extra flops are built; all other behaviour is identical.
// STRUCTURE
//  Package debounce_pkg:
//   - typedef enum logic [0:0] {DB_STABLE, DB_SETTLE} db_state_t.
//   - localparam DB_CLK_HZ = 48_000_000.
//   - localparam DB_DEFAULT_MS = 10, with STABLE_CYCLES default derived from DB_CLK_HZ and DB_DEFAULT_MS.
//  Sub-module sync_ff (params WIDTH, STAGES; ports clk, reset, d, q).
//   - Generic multi-bit synchroniser with the same reset scheme; instantiated once.
//  FSM, counter and optional change-pulse logic stay in switch_debounce.
// TESTING (bench with STABLE_CYCLES=8, SYNC_STAGES=2)
//  1. Reset: reset=0 with s_raw=4'hF -> s_db=0, settling=0. Release and hold 4'hF -> s_db=4'hF after edge 10, settling high for edges 2..9.
//  2. Bounce: from s_db=0, s_raw toggles 0/5 every 3 clocks for 40 clocks, then holds 5 -> s_db stays 0 throughout and becomes 5 exactly 10 edges after the final steady sample.
//  3. Glitch: s_db=4'h3; s_raw=4'h7 for 4 clocks, then back to 3 -> s_db stays 3; settling rises, then falls with no update.
//  4. Partial change: s_db=0; s_raw=4'h1, then 4'h3 5 clocks later -> timer restarts; s_db goes straight to 3 and never shows 1.
//  5. Reset mid-SETTLE: assert reset with cnt=5 -> s_db=0 and settling=0 immediately (async); after release the full 10-edge latency applies again.
//  6. With DEBOUNCE_CHANGE_PULSE_EN: s_db moves 4'h3 -> 4'hA -> changed=1 for one cycle with changed_mask=4'h9; otherwise 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and timing constants for the switch debouncer.
// Default hold time is 10 ms at the 48 MHz HSOSC clock.
package debounce_pkg;

    typedef enum logic [0:0] {
        DB_STABLE,
        DB_SETTLE
    } db_state_t;

    localparam int DB_CLK_HZ     = 48_000_000;
    localparam int DB_DEFAULT_MS = 10;

    localparam int DB_STABLE_CYCLES = (DB_CLK_HZ / 1000) * DB_DEFAULT_MS;

endpackage

// File: rtl/sync_ff.sv
// Multi-bit flop-chain synchroniser for asynchronous inputs.
// Pure shift per bit with no logic between stages; q is the last stage.
module sync_ff #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg <= '0;
        end else begin
            stg <= {stg[STAGES-2:0], d};
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Synchronises and debounces the DIP-switch vector as one unit.
// Define DEBOUNCE_CHANGE_PULSE_EN to add the changed/changed_mask outputs.
module switch_debounce
    import debounce_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_raw,
    output logic [WIDTH-1:0] s_db,
    output logic             settling
`ifdef DEBOUNCE_CHANGE_PULSE_EN
    ,
    output logic             changed,
    output logic [WIDTH-1:0] changed_mask
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    db_state_t        state, state_n;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] cand, cand_n;
    logic [WIDTH-1:0] db_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             accept;

    sync_ff #(
        .WIDTH (WIDTH),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (s_raw),
        .q    (sync)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= DB_STABLE;
            cand  <= '0;
            cnt   <= '0;
            s_db  <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
            s_db  <= db_n;
        end
    end

    // Any disagreement with the candidate restarts the hold window.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        db_n    = s_db;
        accept  = 1'b0;
        case (state)
            DB_STABLE: begin
                if (sync != s_db) begin
                    state_n = DB_SETTLE;
                    cand_n  = sync;
                    cnt_n   = '0;
                end
            end
            DB_SETTLE: begin
                if (sync == s_db) begin
                    state_n = DB_STABLE;
                    cnt_n   = '0;
                end else if (sync != cand) begin
                    cand_n = sync;
                    cnt_n  = '0;
                end else if (cnt == CNT_LAST) begin
                    db_n    = cand;
                    accept  = 1'b1;
                    state_n = DB_STABLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = DB_STABLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        settling = (state == DB_SETTLE);
    end

`ifdef DEBOUNCE_CHANGE_PULSE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            changed      <= 1'b0;
            changed_mask <= '0;
        end else begin
            changed      <= accept;
            changed_mask <= accept ? (s_db ^ cand) : '0;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with STABLE_CYCLES=8, SYNC_STAGES=2.
// Change-pulse scenario runs only when DEBOUNCE_CHANGE_PULSE_EN is defined.
module tb_switch_debounce;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] s_raw = 4'h0;
    logic [3:0] s_db;
    logic       settling;
`ifdef DEBOUNCE_CHANGE_PULSE_EN
    logic       changed;
    logic [3:0] changed_mask;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    switch_debounce #(
        .WIDTH        (4),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_raw       (s_raw),
        .s_db        (s_db),
        .settling    (settling)
`ifdef DEBOUNCE_CHANGE_PULSE_EN
        ,
        .changed     (changed),
        .changed_mask(changed_mask)
`endif
    );

    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_db;
        logic       exp_st;
        #2 reset = 1'b0;
        s_raw = 4'hF;
        repeat (3) @(negedge clk);
        tests_run++;
        if (s_db !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_db got=%h exp=0", s_db);
        end
        tests_run++;
        if (settling !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_settling got=%b exp=0", settling);
        end
        reset = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk);
            #1;
            exp_db = (k >= 10) ? 4'hF : 4'h0;
            exp_st = (k >= 2 && k <= 9);
            tests_run++;
            if (s_db !== exp_db || settling !== exp_st) begin
                tests_failed++;
                $display("FAIL reset_release edge=%0d db=%h st=%b exp db=%h st=%b",
                         k, s_db, settling, exp_db, exp_st);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_db;
        int         bad = 0;
        @(negedge clk);
        s_raw = 4'h0;
        run_edges(12);
        tests_run++;
        if (s_db !== 4'h0) begin
            tests_failed++;
            $display("FAIL bounce_pre got=%h exp=0", s_db);
        end
        for (int i = 0; i < 40; i++) begin
            s_raw = (((i / 3) % 2) == 0) ? 4'h5 : 4'h0;
            @(posedge clk);
            #1;
            if (s_db !== 4'h0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bounce_hold bad_cycles=%0d exp=0", bad);
        end
        s_raw = 4'h5;
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk);
            #1;
            exp_db = (k >= 10) ? 4'h5 : 4'h0;
            tests_run++;
            if (s_db !== exp_db) begin
                tests_failed++;
                $display("FAIL bounce_settle edge=%0d got=%h exp=%h",
                         k, s_db, exp_db);
            end
        end
    endtask

    task automatic test_glitch();
        int bad  = 0;
        int seen = 0;
        @(negedge clk);
        s_raw = 4'h3;
        run_edges(12);
        tests_run++;
        if (s_db !== 4'h3) begin
            tests_failed++;
            $display("FAIL glitch_pre got=%h exp=3", s_db);
        end
        @(negedge clk);
        s_raw = 4'h7;
        repeat (4) @(negedge clk);
        s_raw = 4'h3;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (s_db !== 4'h3) bad++;
            if (settling === 1'b1) seen++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL glitch_db bad_cycles=%0d exp=0", bad);
        end
        tests_run++;
        if (seen == 0) begin
            tests_failed++;
            $display("FAIL glitch_settle_rise seen=%0d exp>0", seen);
        end
        tests_run++;
        if (settling !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_settle_fall got=%b exp=0", settling);
        end
    endtask

    task automatic test_partial();
        logic [3:0] exp_db;
        int         saw_one = 0;
        @(negedge clk);
        s_raw = 4'h0;
        run_edges(12);
        @(negedge clk);
        s_raw = 4'h1;
        repeat (5) @(negedge clk);
        s_raw = 4'h3;
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (s_db === 4'h1) saw_one++;
            exp_db = (k >= 10) ? 4'h3 : 4'h0;
            tests_run++;
            if (s_db !== exp_db) begin
                tests_failed++;
                $display("FAIL partial edge=%0d got=%h exp=%h", k, s_db, exp_db);
            end
        end
        tests_run++;
        if (saw_one != 0) begin
            tests_failed++;
            $display("FAIL partial_no_mix cycles_at_1=%0d exp=0", saw_one);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_db;
        @(negedge clk);
        s_raw = 4'hC;
        repeat (8) @(posedge clk);
        #1;
        tests_run++;
        if (settling !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_pre_settling got=%b exp=1", settling);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (s_db !== 4'h0 || settling !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_async db=%h st=%b exp db=0 st=0",
                     s_db, settling);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk);
            #1;
            exp_db = (k >= 10) ? 4'hC : 4'h0;
            tests_run++;
            if (s_db !== exp_db) begin
                tests_failed++;
                $display("FAIL midrst_relatch edge=%0d got=%h exp=%h",
                         k, s_db, exp_db);
            end
        end
    endtask

`ifdef DEBOUNCE_CHANGE_PULSE_EN
    task automatic test_change_pulse();
        logic       exp_c;
        logic [3:0] exp_m;
        @(negedge clk);
        s_raw = 4'h3;
        run_edges(13);
        @(negedge clk);
        s_raw = 4'hA;
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk);
            #1;
            exp_c = (k == 10);
            exp_m = (k == 10) ? 4'h9 : 4'h0;
            tests_run++;
            if (changed !== exp_c || changed_mask !== exp_m) begin
                tests_failed++;
                $display("FAIL change_pulse edge=%0d c=%b m=%h exp c=%b m=%h",
                         k, changed, changed_mask, exp_c, exp_m);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bounce();
        test_glitch();
        test_partial();
        test_reset_mid();
`ifdef DEBOUNCE_CHANGE_PULSE_EN
        test_change_pulse();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
